// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory among NUM_PORTS requesters with a tagged response pipeline and per-port flush.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority (port 0 highest).
module mem_port_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_LAT   = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        req_valid,
  input  logic [NUM_PORTS-1:0]        req_write,
  input  logic [3*NUM_PORTS-1:0]      req_func3,
  input  logic [ADDR_W*NUM_PORTS-1:0] req_addr,
  input  logic [DATA_W*NUM_PORTS-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]        req_ready,
  input  logic [NUM_PORTS-1:0]        flush,
  output logic [NUM_PORTS-1:0]        rsp_valid,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic                        busy,
  output logic                        mem_read,
  output logic                        mem_write,
  output logic [2:0]                  mem_func3,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata
);

  localparam int PW   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int LAST = MEM_LAT - 1;

  logic                        gnt_any;
  logic [PW-1:0]               gnt_idx;
  int                          idx;
  logic [MEM_LAT-1:0]          tag_vld_q, tag_vld_d;
  logic [MEM_LAT-1:0][PW-1:0]  tag_port_q, tag_port_d;
  logic                        rsp_any;

`ifdef ARB_ROUND_ROBIN_EN
  // ptr_q holds the port where the next search begins (one past the last grant).
  logic [PW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) begin
      if (int'(gnt_idx) == NUM_PORTS - 1) ptr_d = '0;
      else                                ptr_d = gnt_idx + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= '0;
    else      ptr_q <= ptr_d;
  end
`endif

  // Grant is gated by rst so no request leaks to memory while reset is held.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      idx = (int'(ptr_q) + i) % NUM_PORTS;
`else
      idx = i;
`endif
      if (!gnt_any && rst && req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx[PW-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (gnt_any) req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_func3 = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt_any) begin
      mem_read  = !req_write[gnt_idx];
      mem_write = req_write[gnt_idx];
      mem_func3 = req_func3[3*int'(gnt_idx) +: 3];
      mem_addr  = req_addr[ADDR_W*int'(gnt_idx) +: ADDR_W];
      mem_wdata = req_wdata[DATA_W*int'(gnt_idx) +: DATA_W];
    end
  end

  // Flushing a port kills its tags as they move one stage down, and kills a fresh push too.
  always_comb begin
    tag_vld_d     = '0;
    tag_port_d    = '0;
    tag_vld_d[0]  = gnt_any && !flush[gnt_idx];
    tag_port_d[0] = gnt_idx;
    for (int k = 1; k < MEM_LAT; k++) begin
      tag_vld_d[k]  = tag_vld_q[k-1] && !flush[tag_port_q[k-1]];
      tag_port_d[k] = tag_port_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_vld_q  <= '0;
      tag_port_q <= '0;
    end else begin
      tag_vld_q  <= tag_vld_d;
      tag_port_q <= tag_port_d;
    end
  end

  assign rsp_any = tag_vld_q[LAST] && !flush[tag_port_q[LAST]];

  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    if (rsp_any) begin
      rsp_valid[tag_port_q[LAST]] = 1'b1;
      rsp_rdata                   = mem_rdata;
    end
  end

  assign busy = |tag_vld_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter: a queue-based reference model predicts grants and responses.
// Follows ARB_ROUND_ROBIN_EN the same way the design does.
module tb_mem_port_arbiter;
  localparam int NP  = 3;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 3;
  localparam int NCYC = 640;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NP-1:0]     req_valid, req_write, req_ready, flush, rsp_valid;
  logic [3*NP-1:0]   req_func3;
  logic [AW*NP-1:0]  req_addr;
  logic [DW*NP-1:0]  req_wdata;
  logic [DW-1:0]     rsp_rdata, mem_wdata, mem_rdata;
  logic              busy, mem_read, mem_write;
  logic [2:0]        mem_func3;
  logic [AW-1:0]     mem_addr;

  always #5 clk = ~clk;

  mem_port_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_func3(req_func3),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .flush(flush), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .mem_read(mem_read), .mem_write(mem_write), .mem_func3(mem_func3),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit run   = 1'b0;

  typedef struct {
    int          port;
    bit          is_load;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sbq[$];

  function automatic logic [31:0] init_word(int k);
    return 32'(k) * 32'h9E37_79B1 ^ 32'h00C0_FFEE;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory environment: writes at the capture edge, read data appears LAT cycles later.
  logic [DW-1:0] mem [64];
  logic [DW-1:0] rd_pipe [LAT];
  assign mem_rdata = rd_pipe[LAT-1];

  initial begin
    for (int k = 0; k < 64; k++) mem[k] = init_word(k);
    for (int k = 0; k < LAT; k++) rd_pipe[k] = '0;
    forever begin
      @(posedge clk);
      for (int k = LAT-1; k > 0; k--) rd_pipe[k] = rd_pipe[k-1];
      rd_pipe[0] = mem_read ? mem[mem_addr[7:2]] : '0;
      if (mem_write) mem[mem_addr[7:2]] = mem_wdata;
    end
  end

  // Monitor: pops the scoreboard whenever a response is presented or one is overdue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (run) begin
        if (rsp_valid != '0) begin
          if (sbq.size() == 0) begin
            check("rsp_spurious", 64'(rsp_valid), 64'd0);
          end else begin
            e = sbq.pop_front();
            check("rsp_cycle", 64'(cyc), 64'(e.due));
            check("rsp_port", 64'(rsp_valid), 64'(1) << e.port);
            if (e.is_load) check("rsp_data", 64'(rsp_rdata), 64'(e.data));
            $display("[TB] rsp port %0d %s data %h cycle %0d", e.port, e.is_load ? "load" : "store", rsp_rdata, cyc);
          end
        end else begin
          check("rsp_rdata_idle", 64'(rsp_rdata), 64'd0);
          if (sbq.size() != 0 && sbq[0].due <= cyc) begin
            e = sbq.pop_front();
            check("rsp_missing", 64'(rsp_valid), 64'(1) << e.port);
          end
        end
      end
    end
  end

  // Reference model state
  logic [DW-1:0] ref_mem [64];
  bit            pend [NP];
  bit            p_wr [NP];
  logic [2:0]    p_f3 [NP];
  logic [AW-1:0] p_addr [NP];
  logic [DW-1:0] p_wd [NP];
  int            rr;

  task automatic drive_bus();
    for (int p = 0; p < NP; p++) begin
      req_valid[p]            = pend[p];
      req_write[p]            = p_wr[p];
      req_func3[3*p +: 3]     = p_f3[p];
      req_addr[AW*p +: AW]    = p_addr[p];
      req_wdata[DW*p +: DW]   = p_wd[p];
    end
  endtask

  task automatic check_idle_outputs(string tag);
    check({tag, "_ready"}, 64'(req_ready), 64'd0);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_mem"}, {mem_read, mem_write, mem_func3, mem_addr, mem_wdata[26:0]}, 64'd0);
  endtask

  initial begin
    int g, pct, fpct, q, wi;
    exp_t e;
    exp_t keep[$];
    for (int k = 0; k < 64; k++) ref_mem[k] = init_word(k);
    for (int p = 0; p < NP; p++) begin
      pend[p] = 0; p_wr[p] = 0; p_f3[p] = '0; p_addr[p] = '0; p_wd[p] = '0;
    end
    rr = 0;
    flush = '0;
    drive_bus();
    repeat (2) @(posedge clk);
    #1;
    req_valid = '1;
    #1;
    check_idle_outputs("reset");
    req_valid = '0;
    rst = 1'b1;
    run = 1'b1;

    for (int n = 0; n < NCYC; n++) begin
      @(posedge clk);
      cyc++;
      #1;
      if (n == 350) begin
        // Asynchronous reset with transactions in flight: everything pending is lost.
        rst = 1'b0;
        #1;
        check_idle_outputs("midreset");
        sbq.delete();
        for (int p = 0; p < NP; p++) pend[p] = 0;
        rr = 0;
        flush = '0;
        drive_bus();
        @(posedge clk);
        cyc++;
        #1;
        rst = 1'b1;
      end else begin
        if (n < 120)       begin pct = 85;  fpct = 8;  end
        else if (n < 220)  begin pct = 25;  fpct = 15; end
        else if (n < 600)  begin pct = 100; fpct = 6;  end
        else               begin pct = 0;   fpct = 0;  end
        for (int p = 0; p < NP; p++) begin
          if (!pend[p] && $urandom_range(99) < pct) begin
            pend[p]   = 1;
            p_wr[p]   = 1'($urandom_range(1));
            p_f3[p]   = 3'($urandom_range(7));
            p_addr[p] = 32'($urandom_range(63)) << 2;
            p_wd[p]   = $urandom;
          end
          flush[p] = ($urandom_range(99) < fpct);
        end
        drive_bus();
        #1;
        check("busy", 64'(busy), 64'(sbq.size() != 0));

        g = -1;
        for (int i = 0; i < NP; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
          q = (rr + i) % NP;
`else
          q = i;
`endif
          if (g < 0 && pend[q]) g = q;
        end

        if (g >= 0) begin
          check("ready", 64'(req_ready), 64'(1) << g);
          check("mem_strobes", {62'd0, mem_read, mem_write}, {62'd0, !p_wr[g], p_wr[g]});
          check("mem_addr", 64'(mem_addr), 64'(p_addr[g]));
          check("mem_func3", 64'(mem_func3), 64'(p_f3[g]));
          check("mem_wdata", 64'(mem_wdata), 64'(p_wd[g]));
        end else begin
          check("ready_none", 64'(req_ready), 64'd0);
          check("mem_none", {mem_read, mem_write, mem_func3, mem_addr, mem_wdata[26:0]}, 64'd0);
        end

        // Flushed ports lose every response still owed to them, including the one due now.
        keep.delete();
        while (sbq.size() != 0) begin
          e = sbq.pop_front();
          if (!flush[e.port]) keep.push_back(e);
        end
        sbq = keep;

        if (g >= 0) begin
          wi = int'(p_addr[g][7:2]);
          e.port    = g;
          e.is_load = !p_wr[g];
          e.data    = p_wr[g] ? '0 : ref_mem[wi];
          e.due     = cyc + LAT;
          if (p_wr[g]) ref_mem[wi] = p_wd[g];
          if (!flush[g]) sbq.push_back(e);
          $display("[TB] grant port %0d %s addr %h cycle %0d%s", g, p_wr[g] ? "store" : "load",
                   p_addr[g], cyc, flush[g] ? " flushed" : "");
          pend[g] = 0;
          rr = (g + 1) % NP;
        end
      end
    end

    @(negedge clk);
    check("drain", 64'(sbq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
